// File: rtl/clocked_video_rx_pkg.sv
// Shared types for the clocked-video receiver: FIFO word layout, FSM states,
// and sync polarity normalisation.
package clocked_video_rx_pkg;

    localparam int unsigned VID_DATA_W = 24;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [VID_DATA_W-1:0] data;
    } vid_word_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DROP       = 2'd2
    } rx_state_e;

    // Returns 1 when the sync line is at its asserted level.
    function automatic logic sync_active(input logic level, input bit active_high);
        return active_high ? level : ~level;
    endfunction

endpackage

// File: rtl/clocked_video_rx_fifo.sv
// Synchronous show-ahead FIFO of vid_word_t; head word is valid whenever !empty_o.
module clocked_video_rx_fifo
    import clocked_video_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  vid_word_t   wdata_i,
    input  logic        pop_i,
    output vid_word_t   rdata_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    vid_word_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/clocked_video_rx.sv
// Clocked-video receiver: rebuilds an Avalon-ST packet per frame from
// datavalid/h_sync/v_sync, measures frame size, and guards the FIFO against overflow.
module clocked_video_rx
    import clocked_video_rx_pkg::*;
#(
    parameter int unsigned DATA_W           = VID_DATA_W,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned CNT_W            = 12,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_datavalid,
    input  logic              vid_h_sync,
    input  logic              vid_v_sync,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    input  logic              source_ready,
    output logic              source_startofpacket,
    output logic              source_endofpacket,
    output logic [CNT_W-1:0]  frame_width,
    output logic [CNT_W-1:0]  frame_height,
    output logic              frame_done,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int unsigned      AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      GUARD_CNT = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               SYNC_HI   = (SYNC_ACTIVE_HIGH != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Input capture; syncs are stored normalised to active-high.
    logic [DATA_W-1:0] pix_q;
    logic              dv_q, hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic              hs_edge, vs_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q     <= '0;
            dv_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            pix_q     <= vid_data;
            dv_q      <= vid_datavalid;
            hs_q      <= sync_active(vid_h_sync, SYNC_HI);
            vs_q      <= sync_active(vid_v_sync, SYNC_HI);
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
        end
    end

    assign hs_edge = hs_q && !hs_prev_q;
    assign vs_edge = vs_q && !vs_prev_q;

    rx_state_e         state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_sop_q, hold_sop_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              sop_pend_q, sop_pend_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]  last_w_q, last_w_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  height_q, height_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;
    logic [CNT_W-1:0]  pix_base;

    logic              push;
    vid_word_t         push_word;
    vid_word_t         head;
    logic [AW:0]       fifo_count;
    logic              fifo_full, fifo_empty;
    logic              pop;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_sop_d   = hold_sop_q;
        hold_data_d  = hold_data_q;
        sop_pend_d   = sop_pend_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        last_w_d     = last_w_q;
        width_d      = width_q;
        height_d     = height_q;
        done_d       = 1'b0;
        ovf_set      = 1'b0;
        push         = 1'b0;
        push_word    = '0;
        pix_base     = hs_edge ? '0 : pix_cnt_q;

        unique case (state_q)
            WAIT_FRAME, DROP: begin
                if (vs_edge) begin
                    state_d    = ACTIVE;
                    sop_pend_d = 1'b1;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    last_w_d   = '0;
                end
            end
            ACTIVE: begin
                if (vs_edge) begin
                    // A pixel arriving with the vsync edge is discarded.
                    if (hold_valid_q) begin
                        if (!fifo_full) begin
                            push      = 1'b1;
                            push_word = '{sop: hold_sop_q, eop: 1'b1, data: hold_data_q};
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                    hold_valid_d = 1'b0;
                    if (pix_cnt_q != '0) begin
                        width_d  = pix_cnt_q;
                        height_d = sat_inc(line_cnt_q);
                    end else begin
                        width_d  = last_w_q;
                        height_d = line_cnt_q;
                    end
                    done_d     = 1'b1;
                    sop_pend_d = 1'b1;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    last_w_d   = '0;
                end else begin
                    if (hs_edge) begin
                        if (pix_cnt_q != '0) begin
                            line_cnt_d = sat_inc(line_cnt_q);
                            last_w_d   = pix_cnt_q;
                        end
                        pix_cnt_d = '0;
                    end
                    if (dv_q) begin
                        // Last free slot is reserved for the truncating eop word.
                        if (fifo_count >= GUARD_CNT) begin
                            if (hold_valid_q && !fifo_full) begin
                                push      = 1'b1;
                                push_word = '{sop: hold_sop_q, eop: 1'b1, data: hold_data_q};
                            end
                            hold_valid_d = 1'b0;
                            ovf_set      = 1'b1;
                            state_d      = DROP;
                        end else begin
                            if (hold_valid_q) begin
                                push      = 1'b1;
                                push_word = '{sop: hold_sop_q, eop: 1'b0, data: hold_data_q};
                            end
                            hold_valid_d = 1'b1;
                            hold_data_d  = pix_q;
                            hold_sop_d   = sop_pend_q;
                            sop_pend_d   = 1'b0;
                            pix_cnt_d    = sat_inc(pix_base);
                        end
                    end
                end
            end
            default: state_d = WAIT_FRAME;
        endcase

        if (ovf_set)           ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
        else                   ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_FRAME;
            hold_valid_q <= 1'b0;
            hold_sop_q   <= 1'b0;
            hold_data_q  <= '0;
            sop_pend_q   <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            last_w_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_sop_q   <= hold_sop_d;
            hold_data_q  <= hold_data_d;
            sop_pend_q   <= sop_pend_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            last_w_q     <= last_w_d;
            width_q      <= width_d;
            height_q     <= height_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pop = !fifo_empty && source_ready;

    clocked_video_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign source_valid         = !fifo_empty;
    assign source_data          = fifo_empty ? '0 : head.data;
    assign source_startofpacket = !fifo_empty && head.sop;
    assign source_endofpacket   = !fifo_empty && head.eop;
    assign frame_width          = width_q;
    assign frame_height         = height_q;
    assign frame_done           = done_q;
    assign overflow             = ovf_q;

endmodule

// File: tb/tb_clocked_video_rx.sv
// Scoreboard bench for clocked_video_rx (FIFO_DEPTH=4, active-low syncs).
module tb_clocked_video_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] vid_data = '0;
    logic        vid_datavalid = 1'b0;
    logic        vid_h_sync = 1'b1;
    logic        vid_v_sync = 1'b1;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready = 1'b1;
    logic        source_startofpacket;
    logic        source_endofpacket;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic        frame_done;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [23:0] data;
    } beat_t;

    typedef struct {
        logic [11:0] w;
        logic [11:0] h;
    } frm_t;

    beat_t exp_q[$];
    frm_t  frm_q[$];

    always #5 clk = ~clk;

    clocked_video_rx #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .vid_data             (vid_data),
        .vid_datavalid        (vid_datavalid),
        .vid_h_sync           (vid_h_sync),
        .vid_v_sync           (vid_v_sync),
        .source_data          (source_data),
        .source_valid         (source_valid),
        .source_ready         (source_ready),
        .source_startofpacket (source_startofpacket),
        .source_endofpacket   (source_endofpacket),
        .frame_width          (frame_width),
        .frame_height         (frame_height),
        .frame_done           (frame_done),
        .overflow             (overflow),
        .overflow_clr         (overflow_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic px(input logic [23:0] d);
        vid_data      = d;
        vid_datavalid = 1'b1;
        tick();
        vid_datavalid = 1'b0;
    endtask

    task automatic hs();
        vid_h_sync = 1'b0;
        tick();
        vid_h_sync = 1'b1;
    endtask

    task automatic vs();
        vid_v_sync = 1'b0;
        tick();
        vid_v_sync = 1'b1;
    endtask

    task automatic vs_px(input logic [23:0] d);
        vid_v_sync    = 1'b0;
        vid_data      = d;
        vid_datavalid = 1'b1;
        tick();
        vid_v_sync    = 1'b1;
        vid_datavalid = 1'b0;
    endtask

    task automatic exp_beat(input logic sop, input logic eop, input logic [23:0] d);
        beat_t b;
        b.sop  = sop;
        b.eop  = eop;
        b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic exp_frame(input logic [11:0] w, input logic [11:0] h);
        frm_t f;
        f.w = w;
        f.h = h;
        frm_q.push_back(f);
    endtask

    // Monitor: compares every accepted beat and every frame_done pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: unexpected data=%0h sop=%0b eop=%0b, none required",
                             source_data, source_startofpacket, source_endofpacket);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat", {6'd0, source_startofpacket, source_endofpacket, source_data},
                          {6'd0, b.sop, b.eop, b.data});
                end
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_done: unexpected pulse w=%0d h=%0d, none required",
                             frame_width, frame_height);
                end else begin
                    frm_t f;
                    f = frm_q.pop_front();
                    check("frame_width", {20'd0, frame_width}, {20'd0, f.w});
                    check("frame_height", {20'd0, frame_height}, {20'd0, f.h});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        reset_n = 1'b1;
        idle(2);
        check("rst_valid", {31'd0, source_valid}, 32'd0);
        check("rst_data", {8'd0, source_data}, 32'd0);
        check("rst_width", {20'd0, frame_width}, 32'd0);
        check("rst_height", {20'd0, frame_height}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Pixels before the first vsync are discarded.
        hs();
        px(24'hA1); px(24'hA2); px(24'hA3);
        idle(3);
        check("prevs_valid", {31'd0, source_valid}, 32'd0);
        vs();
        idle(2);

        // 4x3 frame, pixels 1..12.
        for (int i = 1; i <= 12; i++)
            exp_beat(i == 1, i == 12, 24'(i));
        exp_frame(12'd4, 12'd3);
        for (int l = 0; l < 3; l++) begin
            hs();
            for (int p = 1; p <= 4; p++) px(24'(l * 4 + p));
        end
        idle(2);
        vs();
        idle(4);
        check("t1_drained", {31'd0, source_valid}, 32'd0);

        // Pixel coinciding with vsync edge is dropped; previous pixel carries eop.
        exp_beat(1'b1, 1'b0, 24'h21);
        exp_beat(1'b0, 1'b0, 24'h22);
        exp_beat(1'b0, 1'b1, 24'h23);
        exp_frame(12'd3, 12'd1);
        hs();
        px(24'h21); px(24'h22); px(24'h23);
        vs_px(24'h24);
        idle(4);

        // Empty frame: no packet, frame_done with zero height.
        exp_frame(12'd0, 12'd0);
        hs();
        idle(2);
        vs();
        idle(4);

        // Overflow with ready low: 3 normal words plus eop-truncated 4th word.
        source_ready = 1'b0;
        exp_beat(1'b1, 1'b0, 24'h31);
        exp_beat(1'b0, 1'b0, 24'h32);
        exp_beat(1'b0, 1'b0, 24'h33);
        exp_beat(1'b0, 1'b1, 24'h34);
        hs();
        for (int i = 1; i <= 8; i++) px(24'(8'h30 + i));
        idle(3);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_stall_valid", {31'd0, source_valid}, 32'd1);
        vs();
        idle(2);
        source_ready = 1'b1;
        idle(6);
        check("ovf_drained", {31'd0, source_valid}, 32'd0);

        exp_beat(1'b1, 1'b0, 24'h41);
        exp_beat(1'b0, 1'b0, 24'h42);
        exp_beat(1'b0, 1'b0, 24'h43);
        exp_beat(1'b0, 1'b1, 24'h44);
        exp_frame(12'd2, 12'd2);
        hs();
        px(24'h41); px(24'h42);
        hs();
        px(24'h43); px(24'h44);
        vs();
        idle(4);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Mid-frame reset abandons the held pixel.
        exp_beat(1'b1, 1'b0, 24'h61);
        exp_beat(1'b0, 1'b0, 24'h62);
        hs();
        px(24'h61); px(24'h62); px(24'h63);
        idle(3);
        reset_n = 1'b0;
        #2;
        check("mid_rst_valid", {31'd0, source_valid}, 32'd0);
        check("mid_rst_width", {20'd0, frame_width}, 32'd0);
        check("mid_rst_height", {20'd0, frame_height}, 32'd0);
        check("mid_rst_done", {31'd0, frame_done}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // After reset the receiver must wait for a vsync before accepting pixels.
        hs();
        px(24'h71); px(24'h72);
        idle(2);
        vs();
        idle(2);
        exp_beat(1'b1, 1'b0, 24'h81);
        exp_beat(1'b0, 1'b1, 24'h82);
        exp_frame(12'd2, 12'd1);
        hs();
        px(24'h81); px(24'h82);
        vs();
        idle(5);

        check("beats_pending", exp_q.size(), 32'd0);
        check("frames_pending", frm_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
